// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-array memory responder with fixed request latency
//
// Purpose: services one read or write at a time from the core's memory access
// controller on an internal array of 2^(ADDR_WIDTH-2) 32-bit words. A request
// accepted in IDLE completes LATENCY cycles later with a one-cycle pulse.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   read_en       read request (sampled only in IDLE)
//   write_en      write request (sampled only in IDLE)
//   addr          byte address
//   word_select   1 = halfword access, 0 = 32-bit word access
//   write_data    store data; halfword stores use bits [15:0]
//   read_data     load result, zero-extended for halfwords; held between reads
//   output_valid  one-cycle pulse, read_data valid
//   write_ready   one-cycle pulse, write committed
//   busy          high while a request is in flight
//   access_error  one-cycle pulse on a rejected request
//
// Optional build macro: MEM_RESPONDER_STALL_INJECT_EN adds lfsr[1:0] extra
// wait cycles per access from an 8-bit Fibonacci LFSR (taps 8,6,5,4).

module mem_responder #(
  parameter int ADDR_WIDTH    = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  word_select,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  output_valid,
  output logic                  write_ready,
  output logic                  busy,
  output logic                  access_error
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ_WAIT  = 2'd1;
  localparam logic [1:0] WRITE_WAIT = 2'd2;
  localparam logic [1:0] RESPOND    = 2'd3;

  localparam logic [4:0] RD_LOAD = 5'(READ_LATENCY - 1);
  localparam logic [4:0] WR_LOAD = 5'(WRITE_LATENCY - 1);

  logic [1:0]            state;
  logic [4:0]            counter;
  logic [ADDR_WIDTH-1:1] cap_addr;
  logic                  cap_hw;
  logic                  cap_write;
  logic [31:0]           cap_wdata;

  logic [31:0] mem [DEPTH];

  logic       aligned;
  logic       accept;
  logic       reject;
  logic [4:0] extra;
  logic [4:0] load_val;
  logic [31:0] rd_word;

  always_comb begin
    aligned  = word_select ? ~addr[0] : (addr[1:0] == 2'b00);
    accept   = (state == IDLE) && (read_en ^ write_en) && aligned;
    reject   = (state == IDLE) && (read_en | write_en) && !accept;
    load_val = (write_en ? WR_LOAD : RD_LOAD) + extra;
    rd_word  = mem[cap_addr[ADDR_WIDTH-1:2]];
  end

`ifdef MEM_RESPONDER_STALL_INJECT_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  // The stall amount comes from the value the LFSR advances to on this accept.
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    extra     = {3'b000, lfsr_next[1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 8'hA5;
    else if (accept)
      lfsr <= lfsr_next;
  end
`else
  always_comb begin
    extra = 5'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= 5'd0;
      read_data    <= 32'd0;
      output_valid <= 1'b0;
      write_ready  <= 1'b0;
      busy         <= 1'b0;
      access_error <= 1'b0;
      cap_addr     <= '0;
      cap_hw       <= 1'b0;
      cap_write    <= 1'b0;
      cap_wdata    <= 32'd0;
    end else begin
      output_valid <= 1'b0;
      write_ready  <= 1'b0;
      access_error <= reject;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_addr  <= addr[ADDR_WIDTH-1:1];
            cap_hw    <= word_select;
            cap_write <= write_en;
            cap_wdata <= write_data;
            counter   <= load_val;
            busy      <= 1'b1;
            // A total latency of one cycle skips the wait state entirely.
            if (load_val == 5'd0)
              state <= RESPOND;
            else
              state <= write_en ? WRITE_WAIT : READ_WAIT;
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          // Leave when the counter is about to reach zero so the pulse lands
          // exactly LATENCY cycles after acceptance.
          counter <= counter - 5'd1;
          if (counter == 5'd1)
            state <= RESPOND;
        end
        RESPOND: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (cap_write) begin
            write_ready <= 1'b1;
          end else begin
            output_valid <= 1'b1;
            if (cap_hw)
              read_data <= {16'd0, cap_addr[1] ? rd_word[31:16] : rd_word[15:0]};
            else
              read_data <= rd_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array commits only on the RESPOND edge, so a reset before then drops the write.
  always_ff @(posedge clk) begin
    if (!reset && state == RESPOND && cap_write) begin
      if (!cap_hw)
        mem[cap_addr[ADDR_WIDTH-1:2]] <= cap_wdata;
      else if (cap_addr[1])
        mem[cap_addr[ADDR_WIDTH-1:2]][31:16] <= cap_wdata[15:0];
      else
        mem[cap_addr[ADDR_WIDTH-1:2]][15:0] <= cap_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [11:0] addr = 12'd0;
  logic        word_select = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic        sel = 1'b0;

  logic [31:0] rd_a, rd_b;
  logic        ov_a, ov_b, wr_a, wr_b, busy_a, busy_b, err_a, err_b;

  logic [31:0] rd_o;
  logic        ov_o, wr_o, busy_o, err_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .read_en(read_en & ~sel), .write_en(write_en & ~sel),
    .addr(addr), .word_select(word_select), .write_data(write_data),
    .read_data(rd_a), .output_valid(ov_a), .write_ready(wr_a),
    .busy(busy_a), .access_error(err_a)
  );

  mem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(3), .WRITE_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .read_en(read_en & sel), .write_en(write_en & sel),
    .addr(addr), .word_select(word_select), .write_data(write_data),
    .read_data(rd_b), .output_valid(ov_b), .write_ready(wr_b),
    .busy(busy_b), .access_error(err_b)
  );

  assign rd_o   = sel ? rd_b   : rd_a;
  assign ov_o   = sel ? ov_b   : ov_a;
  assign wr_o   = sel ? wr_b   : wr_a;
  assign busy_o = sel ? busy_b : busy_a;
  assign err_o  = sel ? err_b  : err_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Returns the stall cycles the DUT will add for the request just accepted.
  task automatic note_accept(output int extra);
    m_lfsr[sel] = lfsr_step(m_lfsr[sel]);
`ifdef MEM_RESPONDER_STALL_INJECT_EN
    extra = int'(m_lfsr[sel][1:0]);
`else
    extra = 0;
`endif
  endtask

  // Issues one request, waits for its pulse, returns in the pulse cycle.
  task automatic do_access(input logic rd, input logic [11:0] a, input logic hw,
                           input logic [31:0] wd, input int base_lat,
                           input bit scramble, output logic [31:0] rdata);
    int lat;
    int extra;
    read_en = rd; write_en = ~rd; addr = a; word_select = hw; write_data = wd;
    tick();
    read_en = 1'b0; write_en = 1'b0;
    note_accept(extra);
    check("busy_after_accept", {31'd0, busy_o}, 32'd1);
    lat = 0;
    while (!(ov_o | wr_o) && lat < 40) begin
      if (scramble) begin
        addr = 12'h020; word_select = ~word_select; write_data = $urandom;
      end
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(base_lat + extra));
    check("pulse_kind", {31'd0, ov_o}, {31'd0, rd});
    check("busy_at_pulse", {31'd0, busy_o}, 32'd0);
    rdata = rd_o;
  endtask

  logic [31:0] d;
  logic [11:0] rd_addrs [10] = '{12'h010, 12'h020, 12'h012, 12'h010, 12'h022,
                                 12'h020, 12'h010, 12'h012, 12'h020, 12'h010};
  logic [31:0] rd_exp [10]   = '{32'hCAFE3344, 32'h0BADF00D, 32'h0000CAFE, 32'hCAFE3344, 32'h00000BAD,
                                 32'h0BADF00D, 32'hCAFE3344, 32'h0000CAFE, 32'h0BADF00D, 32'hCAFE3344};
  logic        rd_hw [10]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int extra;
    m_lfsr[0] = 8'hA5; m_lfsr[1] = 8'hA5;
    tick(); tick();
    reset = 1'b0;
    check("rst_read_data", rd_o, 32'd0);
    check("rst_flags", {28'd0, ov_o, wr_o, busy_o, err_o}, 32'd0);

    // Word write then read.
    do_access(1'b0, 12'h010, 1'b0, 32'hDEADBEEF, 1, 1'b0, d);
    do_access(1'b1, 12'h010, 1'b0, 32'd0, 2, 1'b0, d);
    check("word_rd_010", d, 32'hDEADBEEF);

    // Halfword write into upper lane.
    do_access(1'b0, 12'h010, 1'b0, 32'h11223344, 1, 1'b0, d);
    do_access(1'b0, 12'h012, 1'b1, 32'h0000CAFE, 1, 1'b0, d);
    do_access(1'b1, 12'h010, 1'b0, 32'd0, 2, 1'b0, d);
    check("merged_word", d, 32'hCAFE3344);
    do_access(1'b1, 12'h012, 1'b1, 32'd0, 2, 1'b0, d);
    check("hw_rd_012", d, 32'h0000CAFE);
    do_access(1'b1, 12'h010, 1'b1, 32'd0, 2, 1'b0, d);
    check("hw_rd_010", d, 32'h00003344);

    // Misaligned word read.
    tick();
    read_en = 1'b1; addr = 12'h011; word_select = 1'b0;
    tick();
    read_en = 1'b0;
    check("misalign_err", {31'd0, err_o}, 32'd1);
    check("misalign_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check("misalign_err_clear", {31'd0, err_o}, 32'd0);
    check("misalign_no_valid", {31'd0, ov_o}, 32'd0);

    // Misaligned halfword write.
    write_en = 1'b1; addr = 12'h013; word_select = 1'b1; write_data = 32'h0000FFFF;
    tick();
    write_en = 1'b0;
    check("hw_misalign_err", {31'd0, err_o}, 32'd1);
    tick();
    check("hw_misalign_no_ready", {31'd0, wr_o}, 32'd0);

    // Both enables together.
    read_en = 1'b1; write_en = 1'b1; addr = 12'h010; word_select = 1'b0; write_data = 32'd0;
    tick();
    read_en = 1'b0; write_en = 1'b0;
    check("both_en_err", {31'd0, err_o}, 32'd1);
    check("both_en_busy", {31'd0, busy_o}, 32'd0);
    tick();
    do_access(1'b1, 12'h010, 1'b0, 32'd0, 2, 1'b0, d);
    check("both_en_unchanged", d, 32'hCAFE3344);

    // Back-to-back read after pulse, inputs scrambled during the wait.
    do_access(1'b0, 12'h020, 1'b0, 32'h0BADF00D, 1, 1'b0, d);
    do_access(1'b1, 12'h010, 1'b0, 32'd0, 2, 1'b0, d);
    do_access(1'b1, 12'h010, 1'b0, 32'd0, 2, 1'b1, d);
    check("scrambled_rd", d, 32'hCAFE3344);

    // read_data persists across a write.
    do_access(1'b0, 12'h040, 1'b0, 32'h76543210, 1, 1'b0, d);
    tick();
    check("read_data_hold", rd_o, 32'hCAFE3344);

    // Ten consecutive reads.
    for (int i = 0; i < 10; i++) begin
      do_access(1'b1, rd_addrs[i], rd_hw[i], 32'd0, 2, 1'b0, d);
      check($sformatf("loop_rd_%0d", i), d, rd_exp[i]);
    end

    // Reset during WRITE_WAIT on the latency-3 instance.
    tick();
    sel = 1'b1;
    do_access(1'b0, 12'h030, 1'b0, 32'h13572468, 3, 1'b0, d);
    write_en = 1'b1; addr = 12'h030; word_select = 1'b0; write_data = 32'h55AA55AA;
    tick();
    write_en = 1'b0;
    note_accept(extra);
    check("rst_wait_busy", {31'd0, busy_o}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_flags", {28'd0, ov_o, wr_o, busy_o, err_o}, 32'd0);
    check("midrst_read_data", rd_o, 32'd0);
    reset = 1'b0;
    m_lfsr[0] = 8'hA5; m_lfsr[1] = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_ready", {31'd0, wr_o}, 32'd0);
    end
    do_access(1'b1, 12'h030, 1'b0, 32'd0, 3, 1'b0, d);
    check("old_value_kept", d, 32'h13572468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
